paillier_keygen_stream: RTL and testbench

PAILLIER_KEYGEN_STREAM -- requirements
Module: paillier_keygen_stream

---
 rtl/paillier_keygen_stream_if.sv | 59 +++++
 rtl/paillier_keygen_stream.sv | 161 ++++++++++++++++
 tb/tb_paillier_keygen_stream.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/paillier_keygen_stream_if.sv
// Handshake bundle for paillier_keygen_stream: batch control, prime input, inverse engine, key store.
// reject_count exists only when KEYGEN_PARAM_CHECK_EN is defined.
interface paillier_keygen_stream_if #(
   parameter int DATA_WIDTH    = 128,
   parameter int ADDRESS_WIDTH = 16
);
   localparam int KW = 2 * DATA_WIDTH;

   logic                     start;
   logic [ADDRESS_WIDTH-1:0] num_keys;
   logic                     busy;
   logic                     done;
   logic                     p_valid;
   logic                     p_ready;
   logic [DATA_WIDTH-1:0]    p;
   logic [DATA_WIDTH-1:0]    q;
   logic [ADDRESS_WIDTH-1:0] rd_addr;
   logic                     inv_req_valid;
   logic                     inv_req_ready;
   logic [KW-1:0]            inv_base;
   logic [KW-1:0]            inv_mod;
   logic                     inv_resp_valid;
   logic                     inv_resp_ready;
   logic [KW-1:0]            inv_res;
   logic                     key_valid;
   logic                     key_ready;
   logic [KW-1:0]            n_out;
   logic [KW-1:0]            g_out;
   logic [KW-1:0]            lambda_out;
   logic [KW-1:0]            mu_out;
   logic [ADDRESS_WIDTH-1:0] wr_addr;
   logic                     mem_wr_en;
   logic [ADDRESS_WIDTH-1:0] key_count;
`ifdef KEYGEN_PARAM_CHECK_EN
   logic [ADDRESS_WIDTH-1:0] reject_count;
`endif

   modport master (
      input  start, num_keys, p_valid, p, q, inv_req_ready,
             inv_resp_valid, inv_res, key_ready,
      output busy, done, p_ready, rd_addr, inv_req_valid, inv_base, inv_mod,
             inv_resp_ready, key_valid, n_out, g_out, lambda_out, mu_out,
`ifdef KEYGEN_PARAM_CHECK_EN
             reject_count,
`endif
             wr_addr, mem_wr_en, key_count
   );

   modport slave (
      output start, num_keys, p_valid, p, q, inv_req_ready,
             inv_resp_valid, inv_res, key_ready,
      input  busy, done, p_ready, rd_addr, inv_req_valid, inv_base, inv_mod,
             inv_resp_ready, key_valid, n_out, g_out, lambda_out, mu_out,
`ifdef KEYGEN_PARAM_CHECK_EN
             reject_count,
`endif
             wr_addr, mem_wr_en, key_count
   );
endinterface

// File: rtl/paillier_keygen_stream.sv
// Streams prime pairs into Paillier keys (n, g = n+1, lambda, mu) using an external inverse engine.
// Define KEYGEN_PARAM_CHECK_EN to reject degenerate pairs (p == q, p < 3, q < 3) and expose reject_count.
module paillier_keygen_stream #(
   parameter int DATA_WIDTH    = 128,
   parameter int ADDRESS_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   paillier_keygen_stream_if.master bus
);
   localparam int KW = 2 * DATA_WIDTH;

   typedef enum logic [2:0] {
      IDLE, LOAD, INV_REQ, INV_WAIT, WRITE, DONE
   } state_t;

   state_t                   state_q, state_d;
   logic [KW-1:0]            n_q, n_d;
   logic [KW-1:0]            lambda_q, lambda_d;
   logic [KW-1:0]            mu_q, mu_d;
   logic [ADDRESS_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [ADDRESS_WIDTH-1:0] key_count_q, key_count_d;
   logic [ADDRESS_WIDTH-1:0] num_keys_q, num_keys_d;

   logic [DATA_WIDTH-1:0]    p_m1, q_m1;
   logic [KW-1:0]            n_prod, lambda_prod;
   logic                     pair_ok;

   // Operands are widened to KW before multiplying so the full product is kept.
   assign p_m1        = bus.p - DATA_WIDTH'(1);
   assign q_m1        = bus.q - DATA_WIDTH'(1);
   assign n_prod      = KW'(bus.p) * KW'(bus.q);
   assign lambda_prod = KW'(p_m1) * KW'(q_m1);

`ifdef KEYGEN_PARAM_CHECK_EN
   logic [ADDRESS_WIDTH-1:0] reject_count_q, reject_count_d;

   function automatic logic pair_degenerate(input logic [DATA_WIDTH-1:0] a,
                                            input logic [DATA_WIDTH-1:0] b);
      return (a == b) || (a < DATA_WIDTH'(3)) || (b < DATA_WIDTH'(3));
   endfunction

   assign pair_ok          = !pair_degenerate(bus.p, bus.q);
   assign bus.reject_count = reject_count_q;
`else
   assign pair_ok = 1'b1;
`endif

   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      lambda_d    = lambda_q;
      mu_d        = mu_q;
      rd_addr_d   = rd_addr_q;
      wr_addr_d   = wr_addr_q;
      key_count_d = key_count_q;
      num_keys_d  = num_keys_q;
`ifdef KEYGEN_PARAM_CHECK_EN
      reject_count_d = reject_count_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
`ifdef KEYGEN_PARAM_CHECK_EN
               reject_count_d = '0;
`endif
               if (bus.num_keys != '0) begin
                  rd_addr_d   = '0;
                  wr_addr_d   = '0;
                  key_count_d = '0;
                  num_keys_d  = bus.num_keys;
                  state_d     = LOAD;
               end else begin
                  state_d = DONE;
               end
            end
         end
         LOAD: begin
            if (bus.p_valid) begin
               rd_addr_d = rd_addr_q + ADDRESS_WIDTH'(1);
               if (pair_ok) begin
                  n_d      = n_prod;
                  lambda_d = lambda_prod;
                  state_d  = INV_REQ;
               end
`ifdef KEYGEN_PARAM_CHECK_EN
               else begin
                  reject_count_d = reject_count_q + ADDRESS_WIDTH'(1);
               end
`endif
            end
         end
         INV_REQ: begin
            if (bus.inv_req_ready) state_d = INV_WAIT;
         end
         INV_WAIT: begin
            if (bus.inv_resp_valid) begin
               mu_d    = bus.inv_res;
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (bus.key_ready) begin
               wr_addr_d   = wr_addr_q + ADDRESS_WIDTH'(1);
               key_count_d = key_count_q + ADDRESS_WIDTH'(1);
               state_d     = (key_count_d == num_keys_q) ? DONE : LOAD;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         n_q         <= '0;
         lambda_q    <= '0;
         mu_q        <= '0;
         rd_addr_q   <= '0;
         wr_addr_q   <= '0;
         key_count_q <= '0;
         num_keys_q  <= '0;
`ifdef KEYGEN_PARAM_CHECK_EN
         reject_count_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         lambda_q    <= lambda_d;
         mu_q        <= mu_d;
         rd_addr_q   <= rd_addr_d;
         wr_addr_q   <= wr_addr_d;
         key_count_q <= key_count_d;
         num_keys_q  <= num_keys_d;
`ifdef KEYGEN_PARAM_CHECK_EN
         reject_count_q <= reject_count_d;
`endif
      end
   end

   // Handshake strobes and inverse operands are driven only in their own state.
   assign bus.busy           = (state_q != IDLE);
   assign bus.done           = (state_q == DONE);
   assign bus.p_ready        = (state_q == LOAD);
   assign bus.inv_req_valid  = (state_q == INV_REQ);
   assign bus.inv_base       = (state_q == INV_REQ) ? lambda_q : '0;
   assign bus.inv_mod        = (state_q == INV_REQ) ? n_q : '0;
   assign bus.inv_resp_ready = (state_q == INV_WAIT);
   assign bus.key_valid      = (state_q == WRITE);
   assign bus.mem_wr_en      = (state_q == WRITE) && bus.key_ready;

   assign bus.n_out      = n_q;
   assign bus.g_out      = n_q + KW'(1);
   assign bus.lambda_out = lambda_q;
   assign bus.mu_out     = mu_q;
   assign bus.rd_addr    = rd_addr_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.key_count  = key_count_q;
endmodule

// File: tb/tb_paillier_keygen_stream.sv
// Directed bench for paillier_keygen_stream (DATA_WIDTH 8, ADDRESS_WIDTH 3) with a key scoreboard,
// a scripted inverse-engine responder and a key-store monitor.
module tb_paillier_keygen_stream;
   localparam int DW = 8;
   localparam int AW = 3;
   localparam int KW = 2 * DW;

   typedef struct {
      logic [KW-1:0] n;
      logic [KW-1:0] lambda;
      logic [KW-1:0] mu;
      logic [AW-1:0] wa;
   } key_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   int writes  = 0;
   int dones   = 0;
   int accept_cyc = 0;
   int last_write_cyc = 0;

   key_t          exp_q[$];
   logic [KW-1:0] mu_fifo[$];
   logic [AW-1:0] exp_wr = '0;

   logic [DW-1:0] p_tab [0:6] = '{8'd5, 8'd3, 8'd11, 8'd5, 8'd17, 8'd23, 8'd13};
   logic [DW-1:0] q_tab [0:6] = '{8'd7, 8'd5, 8'd13, 8'd3, 8'd19, 8'd29, 8'd11};

   paillier_keygen_stream_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

   paillier_keygen_stream #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   // Inverse engine: answers each request with the next scripted mu.
   initial begin
      bus.inv_resp_valid = 1'b0;
      bus.inv_res        = '0;
      forever begin
         @(negedge clk);
         if (bus.inv_resp_ready && !bus.inv_resp_valid && mu_fifo.size() > 0) begin
            bus.inv_res        = mu_fifo.pop_front();
            bus.inv_resp_valid = 1'b1;
         end else begin
            bus.inv_resp_valid = 1'b0;
         end
      end
   end

   // Key-store monitor: every write is matched against the scoreboard head.
   initial forever begin
      key_t e;
      @(negedge clk);
      #1;
      if (bus.mem_wr_en) begin
         writes++;
         last_write_cyc = cyc;
         check("sb_has_entry", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("n_out", 32'(bus.n_out), 32'(e.n));
            check("g_out", 32'(bus.g_out), 32'(e.n + 16'd1));
            check("lambda_out", 32'(bus.lambda_out), 32'(e.lambda));
            check("mu_out", 32'(bus.mu_out), 32'(e.mu));
            check("wr_addr", 32'(bus.wr_addr), 32'(e.wa));
         end
      end
      if (bus.done) dones++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no summary, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check_reset_state(input string ph);
      check({ph, "_busy"}, 32'(bus.busy), 0);
      check({ph, "_done"}, 32'(bus.done), 0);
      check({ph, "_p_ready"}, 32'(bus.p_ready), 0);
      check({ph, "_inv_req_valid"}, 32'(bus.inv_req_valid), 0);
      check({ph, "_inv_resp_ready"}, 32'(bus.inv_resp_ready), 0);
      check({ph, "_key_valid"}, 32'(bus.key_valid), 0);
      check({ph, "_mem_wr_en"}, 32'(bus.mem_wr_en), 0);
      check({ph, "_rd_addr"}, 32'(bus.rd_addr), 0);
      check({ph, "_wr_addr"}, 32'(bus.wr_addr), 0);
      check({ph, "_key_count"}, 32'(bus.key_count), 0);
      check({ph, "_n"}, 32'(bus.n_out), 0);
      check({ph, "_g"}, 32'(bus.g_out), 1);
      check({ph, "_lambda"}, 32'(bus.lambda_out), 0);
      check({ph, "_mu"}, 32'(bus.mu_out), 0);
      check({ph, "_inv_base"}, 32'(bus.inv_base), 0);
   endtask

   task automatic do_start(input int k);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.num_keys = AW'(k);
      exp_wr       = '0;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic send_pair(input logic [DW-1:0] pv, input logic [DW-1:0] qv,
                            input logic [KW-1:0] muv, input bit push, input int gap);
      key_t e;
      int k;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      if (push) begin
         e.n      = 16'(pv) * 16'(qv);
         e.lambda = 16'(pv - 8'd1) * 16'(qv - 8'd1);
         e.mu     = muv;
         e.wa     = exp_wr;
         exp_wr   = exp_wr + 3'd1;
         exp_q.push_back(e);
         mu_fifo.push_back(muv);
      end
      bus.p = pv;
      bus.q = qv;
      bus.p_valid = 1'b1;
      k = 0;
      while (!bus.p_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("p_accept_in_time", 32'(bus.p_ready), 1);
      accept_cyc = cyc;
      @(negedge clk);
      bus.p_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      while (bus.busy && k < 400) begin
         @(negedge clk);
         k++;
      end
      check(tag, 32'(bus.busy), 0);
   endtask

   initial begin
      int w0, d0, k;
      bus.start = 1'b0;
      bus.num_keys = '0;
      bus.p_valid = 1'b0;
      bus.p = '0;
      bus.q = '0;
      bus.inv_req_ready = 1'b1;
      bus.key_ready = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;
      @(negedge clk);

      // Single key 5 x 7, engine returns 19
      w0 = writes; d0 = dones;
      do_start(1);
      check("busy_after_start", 32'(bus.busy), 1);
      send_pair(8'd5, 8'd7, 16'd19, 1'b1, 0);
      wait_idle("single_idle");
      check("single_latency", 32'(last_write_cyc - accept_cyc), 3);
      check("single_writes", 32'(writes - w0), 1);
      check("single_done", 32'(dones - d0), 1);
      check("single_wr_addr", 32'(bus.wr_addr), 1);
      check("single_key_count", 32'(bus.key_count), 1);
      check("single_rd_addr", 32'(bus.rd_addr), 1);

      // Back-pressure: key_ready low for 3 cycles in WRITE
      w0 = writes; d0 = dones;
      bus.key_ready = 1'b0;
      do_start(1);
      send_pair(8'd3, 8'd5, 16'd2, 1'b1, 0);
      k = 0;
      while (!bus.key_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      for (int i = 0; i < 3; i++) begin
         check("bp_key_valid", 32'(bus.key_valid), 1);
         check("bp_mem_wr_en", 32'(bus.mem_wr_en), 0);
         check("bp_n", 32'(bus.n_out), 15);
         check("bp_g", 32'(bus.g_out), 16);
         check("bp_lambda", 32'(bus.lambda_out), 8);
         check("bp_mu", 32'(bus.mu_out), 2);
         @(negedge clk);
      end
      check("bp_no_write_yet", 32'(writes - w0), 0);
      bus.key_ready = 1'b1;
      wait_idle("bp_idle");
      check("bp_writes", 32'(writes - w0), 1);
      check("bp_done", 32'(dones - d0), 1);

      // Batch of 3 with p_valid gaps
      w0 = writes; d0 = dones;
      do_start(3);
      send_pair(8'd11, 8'd13, 16'd7, 1'b1, 2);
      send_pair(8'd5, 8'd3, 16'd9, 1'b1, 0);
      send_pair(8'd17, 8'd19, 16'd33, 1'b1, 3);
      wait_idle("batch_idle");
      check("batch_rd_addr", 32'(bus.rd_addr), 3);
      check("batch_wr_addr", 32'(bus.wr_addr), 3);
      check("batch_key_count", 32'(bus.key_count), 3);
      check("batch_writes", 32'(writes - w0), 3);
      check("batch_done", 32'(dones - d0), 1);

      // Start with num_keys == 0 goes straight to DONE
      w0 = writes; d0 = dones;
      do_start(0);
      wait_idle("zero_idle");
      check("zero_done", 32'(dones - d0), 1);
      check("zero_writes", 32'(writes - w0), 0);

      // Reset while waiting on the inverse engine
      w0 = writes; d0 = dones;
      do_start(1);
      send_pair(8'd7, 8'd11, 16'd0, 1'b0, 0);
      k = 0;
      while (!bus.inv_resp_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("inv_wait_reached", 32'(bus.inv_resp_ready), 1);
      rst = 1'b1;
      #1;
      check_reset_state("abort");
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      check("abort_busy", 32'(bus.busy), 0);
      check("abort_no_done", 32'(dones - d0), 0);
      check("abort_no_write", 32'(writes - w0), 0);

      // p == q == 7
      w0 = writes; d0 = dones;
      do_start(1);
`ifdef KEYGEN_PARAM_CHECK_EN
      send_pair(8'd7, 8'd7, 16'd0, 1'b0, 0);
      repeat (3) @(negedge clk);
      check("rej_count", 32'(bus.reject_count), 1);
      check("rej_stay_load", 32'(bus.p_ready), 1);
      check("rej_rd_addr", 32'(bus.rd_addr), 1);
      check("rej_no_write", 32'(writes - w0), 0);
      send_pair(8'd5, 8'd7, 16'd19, 1'b1, 0);
      wait_idle("rej_idle");
      check("rej_rd_addr_final", 32'(bus.rd_addr), 2);
`else
      send_pair(8'd7, 8'd7, 16'd5, 1'b1, 0);
      wait_idle("pq_idle");
      check("pq_n", 32'(bus.n_out), 49);
      check("pq_lambda", 32'(bus.lambda_out), 36);
      check("pq_rd_addr", 32'(bus.rd_addr), 1);
`endif
      check("pq_writes", 32'(writes - w0), 1);

      // Seven keys on a 3-bit address, start during busy ignored, then a batch of 2
      w0 = writes; d0 = dones;
      do_start(7);
      for (int i = 0; i < 7; i++) begin
         send_pair(p_tab[i], q_tab[i], 16'(40 + i), 1'b1, i % 2);
         if (i == 0) begin
            @(negedge clk);
            bus.start    = 1'b1;
            bus.num_keys = 3'd2;
            @(negedge clk);
            bus.start = 1'b0;
         end
      end
      wait_idle("wrap_idle");
      check("wrap_wr_addr", 32'(bus.wr_addr), 7);
      check("wrap_rd_addr", 32'(bus.rd_addr), 7);
      check("wrap_key_count", 32'(bus.key_count), 7);
      check("wrap_writes", 32'(writes - w0), 7);
      check("wrap_done", 32'(dones - d0), 1);
      w0 = writes; d0 = dones;
      do_start(2);
      check("wrap2_wr_addr_start", 32'(bus.wr_addr), 0);
      send_pair(8'd23, 8'd29, 16'd11, 1'b1, 1);
      send_pair(8'd13, 8'd11, 16'd12, 1'b1, 0);
      wait_idle("wrap2_idle");
      check("wrap2_wr_addr_end", 32'(bus.wr_addr), 2);
      check("wrap2_rd_addr_end", 32'(bus.rd_addr), 2);
      check("wrap2_writes", 32'(writes - w0), 2);
      check("wrap2_done", 32'(dones - d0), 1);

      repeat (3) @(negedge clk);
      check("sb_drained", 32'(exp_q.size()), 0);
      check("mu_drained", 32'(mu_fifo.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
